centroid_uart_receiver: RTL
===========================

CENTROID_UART_RECEIVER -- requirements
Module: centroid_uart_receiver

Interface
REQ-001 SHALL have parameter INPUT_CLOCK_FREQ, default 200_000_000, meaning clk_in frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning serial bit rate; CYCLES_PER_BIT = INPUT_CLOCK_FREQ / BAUD_RATE, integer division.
REQ-003 SHALL have parameter IDLE_TIMEOUT_BITS, default 20, meaning the idle-line duration, in bit times, that resynchronises the frame sequencer.
REQ-004 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_in  input  1  reset, synchronous and active-low (0 = reset).
REQ-006 rx_wire_in  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-007 c1_data_out  output  17  first centroid of the last good frame.
REQ-008 c2_data_out  output  17  second centroid of the last good frame.
REQ-009 valid_out  output  1  one-cycle pulse when both centroid outputs update.
REQ-010 frame_error_out  output  1  one-cycle pulse on any framing or sequence error.
REQ-011 busy_out  output  1  high while a frame is partially received.

Function
REQ-012 SHALL pass rx_wire_in through a two-flop synchroniser before any use.
REQ-013 Bit receiver SHALL use states IDLE, START, DATA, STOP.
- IDLE -> START on synchronised high-to-low edge.
- START: re-samples at CYCLES_PER_BIT/2. High means a glitch -> IDLE, no strobe. Low -> DATA.
- DATA: samples 8 bits, one every CYCLES_PER_BIT, LSB first.
REQ-014 STOP SHALL sample the stop bit one CYCLES_PER_BIT after the last data bit.
- Stop = 1: raise an internal byte strobe for one cycle on the next clock.
- Stop = 0: raise an internal framing-error strobe instead, and do not deliver the byte.
- Either way, return to IDLE.
REQ-015 A frame SHALL be six bytes in order: C1 bytes B1, B2, B3, then C2 bytes B1, B2, B3.
REQ-016 Byte classes SHALL be: B1 valid iff byte[7:6]=00, payload c[5:0]=byte[5:0]; B2 valid iff byte[7:6]=01, payload c[11:6]=byte[5:0]; B3 valid iff byte[7:5]=010, payload c[16:12]=byte[4:0].
REQ-017 Class SHALL be decided by expected position, not by tag alone, because B3 bytes also satisfy the B2 tag check.
REQ-018 Sequencer SHALL use states WAIT_C1B1, C1B2, C1B3, C2B1, C2B2, C2B3, RESYNC.
- Each good byte advances one state.
- C2B3 accepted -> WAIT_C1B1.
REQ-019 Payloads SHALL assemble into internal shadow registers; c1_data_out and c2_data_out SHALL change only on valid_out.
REQ-020 valid_out SHALL pulse on the clock after the strobe of the sixth byte; both outputs SHALL update on that same edge.
REQ-021 On a wrong-class byte in any state except WAIT_C1B1 and RESYNC, the sequencer SHALL pulse frame_error_out, discard the shadow data and enter RESYNC.
REQ-022 In WAIT_C1B1, a non-B1 byte SHALL be dropped silently and the state SHALL be held.
REQ-023 A framing-error strobe in any state SHALL pulse frame_error_out (same cycle as the strobe) and enter RESYNC.
REQ-024 RESYNC SHALL ignore all bytes until the synchronised line has been continuously high for IDLE_TIMEOUT_BITS*CYCLES_PER_BIT cycles, then enter WAIT_C1B1.
REQ-025 The same idle timeout in any mid-frame state SHALL pulse frame_error_out and return to WAIT_C1B1; the timeout SHALL have no effect in WAIT_C1B1.
REQ-026 busy_out SHALL be high in states C1B2 through C2B3, and low in WAIT_C1B1 and RESYNC.
REQ-027 valid_out and frame_error_out SHALL never be high in the same cycle.

Reset
REQ-028 While rst_in=0 on a clock edge, both state machines SHALL go to IDLE/WAIT_C1B1 and all counters and shadow registers SHALL clear.
REQ-029 While rst_in=0, all outputs SHALL be 0 and the synchroniser flops SHALL load 1.
REQ-030 Reset asserted mid-byte or mid-frame SHALL discard partial data with no valid_out or frame_error_out pulse.
REQ-031 After reset release, a byte SHALL be accepted only after a fresh falling edge.

Verification (INPUT_CLOCK_FREQ=1_000_000, BAUD_RATE=100_000: 10 cycles/bit)
V-1 Send 0D 6F 5A 00 40 40 -> one valid_out pulse; c1_data_out=17'h1ABCD, c2_data_out=17'h00000; frame_error_out never high.
V-2 Send 0D 6F 0D … -> frame_error_out pulse at the third byte; outputs unchanged; after 200 idle-high cycles, a good frame is accepted.
V-3 Second byte sent with stop bit=0 -> frame_error_out pulse; no valid_out; after resync, the next good frame decodes correctly.
V-4 Send 0D 6F, then hold the line high for 200 cycles -> frame_error_out pulse; busy_out falls; the next good frame is accepted.
V-5 Low glitch of 3 cycles on an idle line -> no strobe, no state change.
V-6 Drive rst_in=0 during the fourth byte -> all outputs 0; after release, a good frame gives valid_out with the correct values.

Source files
------------

// File: rtl/centroid_uart_receiver.sv
// 8N1 serial receiver that assembles two 17-bit centroids
// from tagged six-byte frames with idle-line resynchronisation.
module centroid_uart_receiver #(
  parameter int INPUT_CLOCK_FREQ  = 200_000_000,
  parameter int BAUD_RATE         = 115200,
  parameter int IDLE_TIMEOUT_BITS = 20
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rx_wire_in,
  output logic [16:0] c1_data_out,
  output logic [16:0] c2_data_out,
  output logic        valid_out,
  output logic        frame_error_out,
  output logic        busy_out
);

  localparam int CPB = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int TO  = IDLE_TIMEOUT_BITS * CPB;
  localparam int CW  = $clog2(CPB + 1);
  localparam int TW  = $clog2(TO + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TO);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    WAIT_C1B1, C1B2, C1B3, C2B1, C2B2, C2B3, RESYNC
  } seq_state_t;

  logic rx_meta_q, rx_meta_d;
  logic rx_sync_q, rx_sync_d;
  logic rx_prev_q, rx_prev_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic idle_done;

  rx_state_t rx_state_q, rx_state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic byte_stb_q, byte_stb_d;
  logic ferr_stb_q, ferr_stb_d;

  seq_state_t seq_q, seq_d;
  logic [16:0] s1_q, s1_d;
  logic [16:0] s2_q, s2_d;
  logic [16:0] c1_q, c1_d;
  logic [16:0] c2_q, c2_d;
  logic valid_q, valid_d;
  logic serr_q, serr_d;
  logic bad;
  logic is_b1, is_b2, is_b3;

  // synchroniser chain and idle-line duration counter
  always_comb begin
    rx_meta_d  = rx_wire_in;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    idle_cnt_d = idle_cnt_q;
    if (!rx_sync_q)
      idle_cnt_d = '0;
    else if (idle_cnt_q != TO_MAX)
      idle_cnt_d = idle_cnt_q + 1'b1;
  end

  assign idle_done = (idle_cnt_q == TO_MAX);

  // bit receiver: start qualification, data shift, stop check
  always_comb begin
    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_stb_d = 1'b0;
    ferr_stb_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          bit_cnt_d  = '0;
        end
      end
      RX_START: begin
        if (bit_cnt_q == HALF_M1) begin
          bit_cnt_d  = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (bit_cnt_q == FULL_M1) begin
          bit_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7)
            rx_state_d = RX_STOP;
          else
            bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (bit_cnt_q == FULL_M1) begin
          bit_cnt_d  = '0;
          rx_state_d = RX_IDLE;
          byte_stb_d = rx_sync_q;
          ferr_stb_d = !rx_sync_q;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign is_b1 = (shift_q[7:6] == 2'b00);
  assign is_b2 = (shift_q[7:6] == 2'b01);
  assign is_b3 = (shift_q[7:5] == 3'b010);

  // frame sequencer: class is checked against expected position
  always_comb begin
    seq_d   = seq_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    valid_d = 1'b0;
    serr_d  = 1'b0;
    bad     = 1'b0;
    if (ferr_stb_q) begin
      seq_d = RESYNC;
      s1_d  = '0;
      s2_d  = '0;
    end else if (byte_stb_q) begin
      unique case (seq_q)
        WAIT_C1B1: begin
          if (is_b1) begin
            s1_d  = {11'b0, shift_q[5:0]};
            s2_d  = '0;
            seq_d = C1B2;
          end
        end
        C1B2: begin
          if (is_b2) begin
            s1_d[11:6] = shift_q[5:0];
            seq_d      = C1B3;
          end else bad = 1'b1;
        end
        C1B3: begin
          if (is_b3) begin
            s1_d[16:12] = shift_q[4:0];
            seq_d       = C2B1;
          end else bad = 1'b1;
        end
        C2B1: begin
          if (is_b1) begin
            s2_d[5:0] = shift_q[5:0];
            seq_d     = C2B2;
          end else bad = 1'b1;
        end
        C2B2: begin
          if (is_b2) begin
            s2_d[11:6] = shift_q[5:0];
            seq_d      = C2B3;
          end else bad = 1'b1;
        end
        C2B3: begin
          if (is_b3) begin
            c1_d    = s1_q;
            c2_d    = {shift_q[4:0], s2_q[11:0]};
            valid_d = 1'b1;
            seq_d   = WAIT_C1B1;
          end else bad = 1'b1;
        end
        RESYNC: ;
        default: seq_d = WAIT_C1B1;
      endcase
      if (bad) begin
        serr_d = 1'b1;
        seq_d  = RESYNC;
        s1_d   = '0;
        s2_d   = '0;
      end
    end else if (idle_done) begin
      if (seq_q == RESYNC) begin
        seq_d = WAIT_C1B1;
      end else if (seq_q != WAIT_C1B1) begin
        serr_d = 1'b1;
        seq_d  = WAIT_C1B1;
        s1_d   = '0;
        s2_d   = '0;
      end
    end
  end

  // state registers; synchroniser loads idle level in reset
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      idle_cnt_q <= '0;
      rx_state_q <= RX_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      byte_stb_q <= 1'b0;
      ferr_stb_q <= 1'b0;
      seq_q      <= WAIT_C1B1;
      s1_q       <= '0;
      s2_q       <= '0;
      c1_q       <= '0;
      c2_q       <= '0;
      valid_q    <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      idle_cnt_q <= idle_cnt_d;
      rx_state_q <= rx_state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      byte_stb_q <= byte_stb_d;
      ferr_stb_q <= ferr_stb_d;
      seq_q      <= seq_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      c1_q       <= c1_d;
      c2_q       <= c2_d;
      valid_q    <= valid_d;
      serr_q     <= serr_d;
    end
  end

  assign c1_data_out     = c1_q;
  assign c2_data_out     = c2_q;
  assign valid_out       = valid_q;
  assign frame_error_out = serr_q | ferr_stb_q;
  assign busy_out        = (seq_q != WAIT_C1B1) && (seq_q != RESYNC);

endmodule
